// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder with fixed latency and RV32I sub-word access
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_f3;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic [31:0]   wd_lanes;
    logic [3:0]    be;
    logic          misaligned;
    logic          out_of_range;
    logic          bad_f3;
    logic          err;
    logic          do_access;

    // Decode the latched request: error classification, load extraction and store lane enables
    always_comb begin
        idx          = lat_addr[AW+1:2];
        off          = lat_addr[1:0];
        word         = mem[idx];
        byte_sel     = 8'(word >> {off, 3'b000});
        half_sel     = off[1] ? word[31:16] : word[15:0];
        misaligned   = (lat_f3[1:0] == 2'b01 && off[0]) || (lat_f3[1:0] == 2'b10 && off != 2'b00);
        out_of_range = lat_addr[31:2] >= 30'(DEPTH_WORDS);
        bad_f3       = lat_write ? (lat_f3 > 3'b010) : (lat_f3 == 3'b011 || lat_f3[2:1] == 2'b11);
        err          = misaligned | out_of_range | bad_f3;
        load_data    = lat_f3[1:0] == 2'b00 ? {{24{~lat_f3[2] & byte_sel[7]}}, byte_sel} :
                       lat_f3[1:0] == 2'b01 ? {{16{~lat_f3[2] & half_sel[15]}}, half_sel} : word;
        be           = lat_f3[1:0] == 2'b00 ? 4'b0001 << off :
                       lat_f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wd_lanes     = lat_f3[1:0] == 2'b00 ? {4{lat_wdata[7:0]}} :
                       lat_f3[1:0] == 2'b01 ? {2{lat_wdata[15:0]}} : lat_wdata;
        do_access    = state == WAIT && cnt == 4'd0;
    end

    // RAM write of the enabled byte lanes at the WAIT->RESP edge; contents survive reset
    always_ff @(posedge clk_i) begin
        if (do_access && lat_write && !err)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
    end

    // Transaction FSM: latch request, count latency, register the response, wait for handshake
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_f3    <= 3'd0;
            rdata_q   <= 32'd0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    lat_write <= req_write_i;
                    lat_addr  <= req_addr_i;
                    lat_wdata <= req_wdata_i;
                    lat_f3    <= req_funct3_i;
                    cnt       <= 4'(WAIT_CYCLES);
                    state     <= WAIT;
                end
                WAIT: if (cnt == 4'd0) begin
                    rdata_q <= (err || lat_write) ? 32'd0 : load_data;
                    error_q <= err;
                    state   <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (rsp_ready_i) begin
                    rdata_q <= 32'd0;
                    error_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = state == IDLE;
    assign rsp_valid_o = state == RESP;
    assign busy_o      = state != IDLE;
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the pipeline's data-memory request interface: accepts one load/store request at a time from the memory stage, models a fixed access latency, performs the RV32I byte/half/word access on an internal word-organised RAM, and returns a registered response. Serves as the data-memory model for the 5-stage core and as the reference responder for memory-stage verification. Single outstanding transaction; little-endian.

## Interface
- DEPTH_WORDS, 1024 — RAM depth in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2 — extra access latency cycles, legal range 0..15.

- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept; high only in IDLE.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data; bytes taken from LSBs.
- req_funct3_i  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  requester takes response.
- rsp_rdata_o  out  32  load data, sign/zero-extended; 0 for stores and errors.
- rsp_error_o  out  1  request rejected (misaligned, out of range, illegal funct3).
- busy_o  out  1  high in WAIT or RESP.

## Operation
- FSM states IDLE, WAIT, RESP. Reset: state IDLE, wait counter 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_error_o 0, busy_o 0, req_ready_o 1 once reset_i deasserts. RAM contents are not reset.
- IDLE: accept when req_valid_i & req_ready_o at an edge. Latch write, addr, wdata, funct3. Load counter with WAIT_CYCLES. Go to WAIT.
- WAIT: at each edge, if counter == 0, perform the access and go to RESP. Otherwise decrement.
- Access, performed at the WAIT→RESP edge:
  - Error check: halfword with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ DEPTH_WORDS; load funct3 ∈ {011,110,111}; store funct3 > 010.
  - On error: no RAM write, rsp_error_o=1, rsp_rdata_o=0.
  - Load: select the byte/half at addr[1:0] of word addr[31:2]. LB/LH sign-extend, LBU/LHU zero-extend.
  - Store: write only the addressed byte lanes. SB writes lane addr[1:0] with wdata[7:0]. SH writes lanes addr[1:0], addr[1:0]+1 with wdata[15:0]. rsp_rdata_o=0.
- RESP: rsp_valid_o=1. rsp_rdata_o and rsp_error_o are held stable until rsp_valid_o & rsp_ready_i at an edge, which returns the FSM to IDLE.
- req_valid_i and other request inputs are ignored outside IDLE. A new request presented during RESP waits.
- Counter width is 4 bits.

## Timing
- Accept at edge N → RESP entered at edge N+1+WAIT_CYCLES → rsp_valid_o high in the following cycle.
- WAIT_CYCLES=0: one WAIT cycle, still registered.
- Response handshake at edge M → IDLE. req_ready_o is high from the cycle after M. Earliest next accept is edge M+1.
- Minimum turnaround with rsp_ready_i held high: WAIT_CYCLES+3 cycles per transaction.
- req_ready_o, rsp_valid_o and busy_o decode from registered state only. No combinational path from any input to any output.
- Reset asserted mid-transaction: immediate return to IDLE, outputs to reset values, pending transaction dropped.
  - A store not yet at its WAIT→RESP edge does not modify RAM.
  - A store already performed stays written.
- rsp_ready_i may be held high before rsp_valid_o rises. Handshake then occurs at the first edge with rsp_valid_o high.

## Test plan
- WAIT_CYCLES=2. Issue SW 0x0000_0010 ← 0xDEADBEEF, then LW 0x10.
  - Required: each rsp_valid_o rises 3 edges after accept.
  - LW returns rdata 0xDEADBEEF, error 0.
- Sub-word loads from word 0x10 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- Sub-word stores, then LW 0x10:
  - SB 0x11 ← 0x000000AA → 0xDEADAAEF.
  - Follow with SH 0x12 ← 0x00001234 → 0x1234AAEF.
- Errors, each returning error 1, rdata 0:
  - LW 0x12; SH 0x11 ← 0xFFFF; LW 4*DEPTH_WORDS; load funct3=011.
  - Subsequent LW 0x10 still returns 0x1234AAEF.
- Backpressure: hold rsp_ready_i low 5 cycles.
  - rsp_valid_o and rsp_rdata_o are stable throughout.
  - req_ready_o stays 0 while req_valid_i is held high.
  - Second request is accepted exactly one edge after the response handshake.
- Reset: assert reset_i low during WAIT of SW 0x20 ← 0x55555555.
  - All outputs return to reset values asynchronously.
  - After release, LW 0x20 returns the prior contents; the store is dropped.
